// File: rtl/disp_arb_pkg.sv
// ----------------------------------------------------------------------------
// disp_arb_pkg
// Shared types and constants for the two-requester display arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT, BLANK)
//   NUM_REQ   : number of requesters sharing the display
//   GNT_*     : one-hot grant encodings driven on gnt
// ----------------------------------------------------------------------------
package disp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    localparam logic [NUM_REQ-1:0] GNT_NONE = 2'b00;
    localparam logic [NUM_REQ-1:0] GNT0     = 2'b01;
    localparam logic [NUM_REQ-1:0] GNT1     = 2'b10;

    // One-hot grant for a single requester index.
    function automatic logic [NUM_REQ-1:0] gnt_for(input logic idx);
        return idx ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/display_arbiter_timer.sv
// ----------------------------------------------------------------------------
// arb_timer
// Loadable down-counter with a zero flag. Load wins over decrement; the
// decrement saturates at zero.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset (count cleared to 0)
//   load     : load load_val this cycle
//   load_val : value loaded into the counter
//   dec      : decrement by one when nonzero
//   zero     : high while the count is zero
// ----------------------------------------------------------------------------
module arb_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/display_arbiter.sv
// ----------------------------------------------------------------------------
// display_arbiter
// Shares one display controller between two requesters. A grant is held for
// at least DWELL cycles; switching between requesters inserts BLANK_CYC
// cycles of BLANK_VAL so the two images never abut on the display.
// Round-robin: the requester not granted most recently has priority.
//
// Parameters:
//   DWELL     : minimum grant length in cycles (2..65535)
//   BLANK_CYC : blanking length between different grants (1..255)
//   BLANK_VAL : seg value while idle or blanking
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset
//   req      : per-requester level request
//   data0/1  : eight hex digits from requester 0 / 1
//   lock     : (only with DISP_ARB_LOCK_EN) hold grant past dwell expiry
//   gnt      : registered one-hot or zero grant
//   seg      : registered value for the display controller seg input
//   busy     : high in GRANT or BLANK
//   switched : one-cycle pulse on the first cycle of each new grant
//
// Build option: define DISP_ARB_LOCK_EN to add the lock input.
// ----------------------------------------------------------------------------
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int          DWELL     = 1024,
    parameter int          BLANK_CYC = 4,
    parameter logic [31:0] BLANK_VAL = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [31:0]        data0,
    input  logic [31:0]        data1,
`ifdef DISP_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        seg,
    output logic               busy,
    output logic               switched
);

    localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);
    localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYC - 1);

    state_t state, next_state;

    // owner: requester currently granted, or (in BLANK) the one just released
    logic owner, next_owner;
    logic prio_ptr, next_prio;
    logic other;
    logic idle_winner;
    logic lock_hold;

    logic dwell_zero, dwell_load, dwell_dec;
    logic blank_zero, blank_load, blank_dec;

    logic [NUM_REQ-1:0] gnt_d;
    logic [31:0]        seg_d;
    logic               busy_d;
    logic               switched_d;

`ifdef DISP_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign other       = ~owner;
    assign idle_winner = req[prio_ptr] ? prio_ptr : ~prio_ptr;

    arb_timer #(.WIDTH(16)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (DWELL_LOAD),
        .dec      (dwell_dec),
        .zero     (dwell_zero)
    );

    arb_timer #(.WIDTH(8)) u_blank (
        .clk      (clk),
        .reset    (reset),
        .load     (blank_load),
        .load_val (BLANK_LOAD),
        .dec      (blank_dec),
        .zero     (blank_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            prio_ptr <= 1'b0;
            gnt      <= GNT_NONE;
            seg      <= BLANK_VAL;
            busy     <= 1'b0;
            switched <= 1'b0;
        end else begin
            state    <= next_state;
            owner    <= next_owner;
            prio_ptr <= next_prio;
            gnt      <= gnt_d;
            seg      <= seg_d;
            busy     <= busy_d;
            switched <= switched_d;
        end
    end

    always_comb begin
        next_state = state;
        next_owner = owner;

        case (state)
            IDLE: begin
                if (req != GNT_NONE) begin
                    next_state = GRANT;
                    next_owner = idle_winner;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    next_state = req[other] ? BLANK : IDLE;
                end else if (dwell_zero && req[other] && !lock_hold) begin
                    next_state = BLANK;
                end
            end
            BLANK: begin
                // BLANK always runs to completion; requests are only looked
                // at once the blank counter has expired.
                if (blank_zero) begin
                    if (req[other]) begin
                        next_state = GRANT;
                        next_owner = other;
                    end else if (req[owner]) begin
                        next_state = GRANT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state register. seg only carries data while a grant continues,
        // giving the one-cycle lag and a blank seg on the first BLANK cycle.
        gnt_d      = (next_state == GRANT) ? gnt_for(next_owner) : GNT_NONE;
        seg_d      = ((state == GRANT) && (next_state == GRANT))
                     ? (owner ? data1 : data0) : BLANK_VAL;
        busy_d     = (next_state != IDLE);
        switched_d = (next_state == GRANT) && (state != GRANT);

        next_prio  = prio_ptr;
        if (switched_d) begin
            next_prio = ~next_owner;
        end

        // Reload on grant entry and on every expiry while the grant is kept.
        dwell_load = (next_state == GRANT) && ((state != GRANT) || dwell_zero);
        dwell_dec  = (state == GRANT);
        blank_load = (next_state == BLANK) && (state != BLANK);
        blank_dec  = (state == BLANK);
    end

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
`ifdef DISP_ARB_LOCK_EN
    logic        lock;
`endif
    logic [1:0]  gnt;
    logic [31:0] seg;
    logic        busy;
    logic        switched;

    int checks;
    int fails;

    display_arbiter #(
        .DWELL     (8),
        .BLANK_CYC (2),
        .BLANK_VAL (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
`ifdef DISP_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .seg      (seg),
        .busy     (busy),
        .switched (switched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two cycles with the given request, release at a negedge.
    task automatic do_reset(input logic [1:0] r);
        reset = 1'b0;
        req   = r;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
        checks++; if (seg !== 32'h0) begin fails++; $display("[TB] FAIL reset_seg: got %h expected 00000000", seg); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (switched !== 1'b0) begin fails++; $display("[TB] FAIL reset_switched: got %b expected 0", switched); end
        do_reset(2'b00);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL idle_gnt: got %b expected 00", gnt); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        data0 = 32'h1234_5678;
        do_reset(2'b01);
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 2'b01) begin fails++; $display("[TB] FAIL midrst_pre_gnt: got %b expected 01", gnt); end
        #2 reset = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL midrst_gnt: got %b expected 00", gnt); end
        checks++; if (seg !== 32'h0) begin fails++; $display("[TB] FAIL midrst_seg: got %h expected 00000000", seg); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL midrst_idle_gnt: got %b expected 00", gnt); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int pulses;
        logic [31:0] exp_seg;
        pulses = 0;
        data0  = 32'hDEAD_BEEF;
        data1  = 32'h5555_AAAA;
        do_reset(2'b01);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_seg = (k == 1) ? 32'h0 : 32'hDEAD_BEEF;
            if (switched === 1'b1) pulses++;
            checks++; if (gnt !== 2'b01) begin fails++; $display("[TB] FAIL single_gnt cycle %0d: got %b expected 01", k, gnt); end
            checks++; if (seg !== exp_seg) begin fails++; $display("[TB] FAIL single_seg cycle %0d: got %h expected %h", k, seg, exp_seg); end
        end
        checks++; if (pulses != 1) begin fails++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_alternate();
        int p;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_seg;
        logic        exp_sw;
        data0 = 32'hA0A0_A0A0;
        data1 = 32'hB1B1_B1B1;
        do_reset(2'b11);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            p = (k - 1) % 20;
            if (p < 8)       exp_gnt = 2'b01;
            else if (p < 10) exp_gnt = 2'b00;
            else if (p < 18) exp_gnt = 2'b10;
            else             exp_gnt = 2'b00;
            if (p >= 1 && p <= 7)        exp_seg = 32'hA0A0_A0A0;
            else if (p >= 11 && p <= 17) exp_seg = 32'hB1B1_B1B1;
            else                         exp_seg = 32'h0;
            exp_sw = (p == 0) || (p == 10);
            checks++; if (gnt !== exp_gnt) begin fails++; $display("[TB] FAIL alt_gnt cycle %0d: got %b expected %b", k, gnt, exp_gnt); end
            checks++; if (seg !== exp_seg) begin fails++; $display("[TB] FAIL alt_seg cycle %0d: got %h expected %h", k, seg, exp_seg); end
            checks++; if (switched !== exp_sw) begin fails++; $display("[TB] FAIL alt_switched cycle %0d: got %b expected %b", k, switched, exp_sw); end
            checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL alt_busy cycle %0d: got %b expected 1", k, busy); end
        end
    endtask

    task automatic test_drop_idle();
        do_reset(2'b01);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (gnt !== 2'b01) begin fails++; $display("[TB] FAIL drop_gnt cycle %0d: got %b expected 01", k, gnt); end
        end
        req = 2'b00;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL drop_idle_gnt: got %b expected 00", gnt); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL drop_idle_busy: got %b expected 0", busy); end
        // Requester 0 was granted last, so requester 1 wins a tie now.
        req = 2'b11;
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin fails++; $display("[TB] FAIL rr_tie_gnt: got %b expected 10", gnt); end
        checks++; if (switched !== 1'b1) begin fails++; $display("[TB] FAIL rr_tie_switched: got %b expected 1", switched); end
    endtask

    task automatic test_drop_to_other();
        do_reset(2'b01);
        repeat (2) @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL d2o_blank1_gnt: got %b expected 00", gnt); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL d2o_blank1_busy: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL d2o_blank2_gnt: got %b expected 00", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin fails++; $display("[TB] FAIL d2o_grant_gnt: got %b expected 10", gnt); end
        checks++; if (switched !== 1'b1) begin fails++; $display("[TB] FAIL d2o_switched: got %b expected 1", switched); end
    endtask

    task automatic test_blank_drop();
        do_reset(2'b11);
        repeat (9) @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL bd_blank1_gnt: got %b expected 00", gnt); end
        req = 2'b01;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin fails++; $display("[TB] FAIL bd_blank2_gnt: got %b expected 00", gnt); end
        checks++; if (seg !== 32'h0) begin fails++; $display("[TB] FAIL bd_blank2_seg: got %h expected 00000000", seg); end
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin fails++; $display("[TB] FAIL bd_regrant_gnt: got %b expected 01", gnt); end
        checks++; if (switched !== 1'b1) begin fails++; $display("[TB] FAIL bd_regrant_switched: got %b expected 1", switched); end
    endtask

`ifdef DISP_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_gnt;
        lock = 1'b1;
        do_reset(2'b11);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_gnt = (k <= 16) ? 2'b01 : 2'b00;
            checks++; if (gnt !== exp_gnt) begin fails++; $display("[TB] FAIL lock_gnt cycle %0d: got %b expected %b", k, gnt, exp_gnt); end
            if (k == 12) lock = 1'b0;
        end
    endtask
`endif

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        req    = 2'b00;
        data0  = 32'h0;
        data1  = 32'h0;
`ifdef DISP_ARB_LOCK_EN
        lock   = 1'b0;
`endif
        test_reset();
        test_reset_mid();
        test_single();
        test_alternate();
        test_drop_idle();
        test_drop_to_other();
        test_blank_drop();
`ifdef DISP_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
